// File: rtl/rip_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rip_div_seq
//  Description : Radix-2 restoring sequencer for RV32M DIV/DIVU/REM/REMU.
//                Optional macro RIP_DIV_EARLY_OUT_EN skips CALC when |a| < |b|.
//  Revision    : 1.0 - initial release
// ============================================================================
module rip_div_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic                  flush,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  busy,
    output logic                  ex_stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] c_min_neg  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  c_cnt_init = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0]  c_cnt_one  = CNT_WIDTH'(1);

    state_t                r_state;
    logic [1:0]            r_op;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic [DATA_WIDTH-1:0] r_mag_b;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_rsp_result;

    logic                  w_signed;
    logic                  w_sign_a;
    logic                  w_sign_b;
    logic [DATA_WIDTH-1:0] w_mag_a;
    logic [DATA_WIDTH-1:0] w_mag_b;
    logic                  w_div_zero;
    logic                  w_ovf;
    logic [DATA_WIDTH-1:0] w_rem_sh;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_fix_quo;
    logic [DATA_WIDTH-1:0] w_fix_rem;

    // Odd opcodes (DIVU/REMU) are unsigned; the most-negative value keeps its
    // sign and its magnitude wraps to 2^(W-1), which is correct as unsigned.
    assign w_signed   = ~req_op[0];
    assign w_sign_a   = w_signed & req_a[DATA_WIDTH-1];
    assign w_sign_b   = w_signed & req_b[DATA_WIDTH-1];
    assign w_mag_a    = w_sign_a ? ('0 - req_a) : req_a;
    assign w_mag_b    = w_sign_b ? ('0 - req_b) : req_b;
    assign w_div_zero = (req_b == '0);
    assign w_ovf      = w_signed & (req_a == c_min_neg) & (req_b == '1);

`ifdef RIP_DIV_EARLY_OUT_EN
    logic w_early;
    assign w_early = (w_mag_a < w_mag_b);
`endif

    assign w_rem_sh  = {r_rem[DATA_WIDTH-2:0], r_quo[DATA_WIDTH-1]};
    assign w_ge      = (w_rem_sh >= r_mag_b);
    assign w_fix_quo = (r_sign_a ^ r_sign_b) ? ('0 - r_quo) : r_quo;
    assign w_fix_rem = r_sign_a ? ('0 - r_rem) : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= 2'd0;
            r_sign_a     <= 1'b0;
            r_sign_b     <= 1'b0;
            r_mag_b      <= '0;
            r_quo        <= '0;
            r_rem        <= '0;
            r_cnt        <= '0;
            r_rsp_result <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op     <= req_op;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_mag_b  <= w_mag_b;
                        if (w_div_zero) begin
                            r_quo        <= '1;
                            r_rem        <= req_a;
                            r_rsp_result <= req_op[1] ? req_a : '1;
                            r_state      <= S_DONE;
                        end else if (w_ovf) begin
                            r_quo        <= c_min_neg;
                            r_rem        <= '0;
                            r_rsp_result <= req_op[1] ? '0 : c_min_neg;
                            r_state      <= S_DONE;
                        end
`ifdef RIP_DIV_EARLY_OUT_EN
                        else if (w_early) begin
                            r_quo   <= '0;
                            r_rem   <= w_mag_a;
                            r_state <= S_FIX;
                        end
`endif
                        else begin
                            // Dividend is shifted out of r_quo as quotient bits shift in.
                            r_quo   <= w_mag_a;
                            r_rem   <= '0;
                            r_cnt   <= c_cnt_init;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_quo <= {r_quo[DATA_WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? (w_rem_sh - r_mag_b) : w_rem_sh;
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_rsp_result <= r_op[1] ? w_fix_rem : w_fix_quo;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign rsp_valid  = (r_state == S_DONE) & ~flush;
    assign rsp_result = r_rsp_result;
    assign ex_stall   = (req_valid & ~rsp_valid) | (busy & ~rsp_valid);

endmodule
`default_nettype wire

// File: tb/tb_rip_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rip_div_seq
//  Description : Directed vector bench for rip_div_seq (DATA_WIDTH = 32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rip_div_seq;

    localparam int c_w        = 32;
    localparam int c_lat_norm = 34;
    localparam int c_lat_spec = 1;
`ifdef RIP_DIV_EARLY_OUT_EN
    localparam int c_lat_early = 2;
`else
    localparam int c_lat_early = 34;
`endif

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_op;
    logic [c_w-1:0] req_a;
    logic [c_w-1:0] req_b;
    logic           flush;
    logic           rsp_valid;
    logic [c_w-1:0] rsp_result;
    logic           busy;
    logic           ex_stall;

    int checks = 0;
    int errors = 0;

    rip_div_seq #(.DATA_WIDTH(c_w)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .busy       (busy),
        .ex_stall   (ex_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = full iteration, 1 = special case, 2 = |a| < |b|
    typedef struct {
        logic [1:0]     op;
        logic [c_w-1:0] a;
        logic [c_w-1:0] b;
        logic [c_w-1:0] exp;
        int             kind;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [c_w-1:0] got, input logic [c_w-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Entered #1 after a posedge with the DUT idle; returns #1 after the
    // posedge that follows the response cycle.
    task automatic run_op(input string name, input logic [1:0] op, input logic [c_w-1:0] a,
                          input logic [c_w-1:0] b, input logic [c_w-1:0] exp, input int exp_lat);
        int  lat;
        bit  seen;
        bit  stall_ok;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(negedge clk);
        check({name, " ready"}, {31'd0, req_ready & ex_stall}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = ~op;
        req_a     = ~a;
        req_b     = ~b;
        lat       = 0;
        seen      = 1'b0;
        stall_ok  = 1'b1;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                lat  = k;
                if (ex_stall || req_ready) stall_ok = 1'b0;
            end else if (!ex_stall || req_ready) begin
                stall_ok = 1'b0;
            end
            @(posedge clk);
            #1;
            if (seen) check({name, " result"}, rsp_result, exp);
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " stall"}, {31'd0, stall_ok}, 32'd1);
        check({name, " idle_after"}, {30'd0, req_ready, busy}, 32'd2);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{2'd1, 32'd100,       32'd7,        32'd14,       0};
        vecs[1]  = '{2'd3, 32'd100,       32'd7,        32'd2,        0};
        vecs[2]  = '{2'd0, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 0};
        vecs[3]  = '{2'd2, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 0};
        vecs[4]  = '{2'd0, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 0};
        vecs[5]  = '{2'd2, 32'd7,         32'hFFFFFFFE, 32'd1,        0};
        vecs[6]  = '{2'd1, 32'd5,         32'd0,        32'hFFFFFFFF, 1};
        vecs[7]  = '{2'd2, 32'h80000000,  32'd0,        32'h80000000, 1};
        vecs[8]  = '{2'd0, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
        vecs[9]  = '{2'd2, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1};
        vecs[10] = '{2'd3, 32'd5,         32'd0,        32'd5,        1};
        vecs[11] = '{2'd2, 32'hFFFFFFFB,  32'd0,        32'hFFFFFFFB, 1};
        vecs[12] = '{2'd0, 32'h80000000,  32'd2,        32'hC0000000, 0};
        vecs[13] = '{2'd0, 32'h80000000,  32'h80000000, 32'd1,        0};
        vecs[14] = '{2'd0, 32'h80000000,  32'd1,        32'h80000000, 0};
        vecs[15] = '{2'd1, 32'd3,         32'd10,       32'd0,        2};
        vecs[16] = '{2'd2, 32'hFFFFFFFD,  32'd10,       32'hFFFFFFFD, 2};
        vecs[17] = '{2'd0, 32'hFFFFFFFD,  32'd10,       32'd0,        2};
        vecs[18] = '{2'd1, 32'd30,        32'd10,       32'd3,        0};
        vecs[19] = '{2'd3, 32'hFFFFFFFF,  32'hFFFFFFFE, 32'd1,        0};
        vecs[20] = '{2'd1, 32'hFFFFFFFE,  32'hFFFFFFFF, 32'd0,        2};
        vecs[21] = '{2'd0, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'd14,       0};
        vecs[22] = '{2'd2, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'hFFFFFFFE, 0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = '0;
        req_b     = '0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", {31'd0, req_ready}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset rsp_result", rsp_result, 32'd0);
        check("reset ex_stall", {31'd0, ex_stall}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            lat = (vecs[i].kind == 1) ? c_lat_spec : (vecs[i].kind == 2) ? c_lat_early : c_lat_norm;
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, lat);
        end

        // Flush mid-CALC: raised in cycle N+10, idle in N+11, never responds.
        req_op    = 2'd1;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush idle", {29'd0, req_ready, busy, rsp_valid}, 32'd4);
        begin
            bit any_rsp;
            any_rsp = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (rsp_valid) any_rsp = 1'b1;
            end
            check("flush no_rsp", {31'd0, any_rsp}, 32'd0);
        end
        @(posedge clk);
        #1;
        run_op("post_flush", 2'd1, 32'd9, 32'd3, 32'd3, c_lat_norm);

        // Flush in the DONE cycle suppresses the pulse.
        req_op    = 2'd1;
        req_a     = 32'd50;
        req_b     = 32'd5;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        check("done_flush busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        check("done_flush rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("done_flush idle", {31'd0, busy}, 32'd0);

        // Flush coincident with a request: not accepted.
        req_op    = 2'd1;
        req_a     = 32'd8;
        req_b     = 32'd2;
        req_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_req not_accepted", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-CALC.
        run_op("pre_reset", 2'd1, 32'd100, 32'd7, 32'd14, c_lat_norm);
        req_op    = 2'd3;
        req_a     = 32'd100;
        req_b     = 32'd7;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst state", {29'd0, req_ready, busy, rsp_valid}, 32'd4);
        check("async_rst rsp_result", rsp_result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_reset", 2'd3, 32'd10, 32'd4, 32'd2, c_lat_norm);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rip_div_seq.md
Name: rip_div_seq

Overview:
Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU. It replaces the single-cycle combinational divide path in the execute stage with a radix-2 restoring iteration engine.
- Takes operands from EX through a valid/ready handshake.
- Holds ex_stall while an operation is in flight.
- Returns a one-cycle result pulse that EX captures into its result register.
- A flush input squashes in-flight work on a pipeline redirect.

Parameters:
- DATA_WIDTH, 32, operand/result width. Must be a power of two, ≥8.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  EX presents a divide op.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
- req_a  in  DATA_WIDTH  dividend (rs1).
- req_b  in  DATA_WIDTH  divisor (rs2).
- flush  in  1  abort in-flight op (branch/trap redirect).
- rsp_valid  out  1  one-cycle pulse; rsp_result valid.
- rsp_result  out  DATA_WIDTH  quotient or remainder per latched op.
- busy  out  1  state != IDLE.
- ex_stall  out  1  = (req_valid & ~rsp_valid) | (busy & ~rsp_valid); EX freezes while high.

Behaviour:
- Reset (rst_n low, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, busy=0, counter=0, all operand/partial registers 0.
- States: IDLE, CALC, FIX, DONE.
- Accept: req_valid & req_ready sampled at posedge N. Latches op, sign_a, sign_b and magnitudes |a|, |b|.
  - Signed ops take two's-complement magnitude.
  - Unsigned ops take the raw operand.
  - Sign of most-negative input is kept, magnitude = 2^(DATA_WIDTH-1).
- Special cases at accept, state → DONE directly (rsp_valid at cycle N+1):
  - b==0: quotient = all ones, remainder = a (raw). Applies to signed and unsigned.
  - Signed only, a==0x80000000 and b==0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Normal path:
  - IDLE→CALC with counter = DATA_WIDTH.
  - CALC performs one restoring step per cycle:
    - rem = {rem[W-2:0], quo[W-1]}; quo <<= 1.
    - If rem ≥ |b|: rem −= |b|, quo[0]=1.
    - counter−−.
  - Leave CALC→FIX when counter reaches 1 on the step being performed (exactly DATA_WIDTH steps).
  - FIX: signed ops negate the quotient if sign_a^sign_b and negate the remainder if sign_a (remainder takes dividend's sign). Unsigned ops pass through.
  - FIX→DONE.
- DONE: rsp_valid=1 for exactly this cycle; rsp_result = quotient (DIV/DIVU) or remainder (REM/REMU). Next edge → IDLE.
- Latency, normal path at DATA_WIDTH=32: accept at N; CALC N+1..N+32; FIX N+33; DONE (rsp_valid) N+34.
- rsp_result holds its last value until the next DONE. It is never cleared except by reset.
- req_ready=0 in CALC/FIX/DONE. A new request can be accepted in the cycle after DONE, not during DONE (no back-to-back overlap).
- ex_stall is combinational. It is low in the DONE cycle so EX advances and captures rsp_result on that edge.
- flush:
  - Highest priority after reset, any state: next state = IDLE, no rsp_valid issued.
  - flush in DONE still suppresses rsp_valid (gated combinationally).
  - flush coincident with req_valid in IDLE: request is not accepted.
- Reset asserted mid-operation: immediate return to reset values; no partial response.
- req_op, req_a and req_b are ignored after accept. EX may change them freely.

Optional Feature:
RIP_DIV_EARLY_OUT_EN
- Defined: at accept, if |a| < |b| (unsigned magnitude compare, after the special-case checks), skip CALC. Load quotient=0, remainder=|a|, go to FIX. rsp_valid at N+2, and the result equals the normal path's.
- Undefined: every non-special op takes the full DATA_WIDTH+2 cycle path. No comparator is instantiated.

Test Plan:
1. DIVU a=100, b=7: accept at N → rsp_valid only at N+34, result 14. REMU same operands → 2. ex_stall high N..N+33, low at N+34.
2. DIV a=−7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (−3). REM same → 0xFFFFFFFF (−1). DIV a=7, b=−2 → 0xFFFFFFFD.
3. b=0: DIVU a=5 → 0xFFFFFFFF at N+1; REM a=0x80000000 → 0x80000000 at N+1. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM same → 0 at N+1.
4. flush raised at N+10 of DIVU 1000/3 → IDLE at N+11, no rsp_valid ever, req_ready=1 at N+11. Next DIVU 9/3 → 3 with normal latency.
5. rst_n dropped asynchronously mid-CALC (between edges) → busy=0, req_ready=1, rsp_valid=0 immediately, rsp_result=0. After release, REMU 10/4 → 2.
6. RIP_DIV_EARLY_OUT_EN defined: DIVU 3/10 → 0 at N+2; REM −3/10 → 0xFFFFFFFD at N+2. DIVU 30/10 still takes N+34. Undefined: DIVU 3/10 → 0 at N+34.
